// File: rtl/irrig_pkg.sv
// Shared types and constants for the irrigation valve scheduler.
package irrig_pkg;

  localparam int unsigned REQ_W = 4;

  localparam int unsigned V_Z1A = 0;
  localparam int unsigned V_Z1B = 1;
  localparam int unsigned V_Z2A = 2;
  localparam int unsigned V_Z2B = 3;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t IDLE  = 2'd0;
  localparam sched_state_t GRANT = 2'd1;
  localparam sched_state_t GUARD = 2'd2;
  localparam sched_state_t FAULT = 2'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/irrig_rr_picker.sv
// Combinational valve selector: first MAX_OPEN requests in round-robin order from ptr.
// IRRIG_ZONE1_PRIORITY_EN scans zone 1 before zone 2, rotating only within each zone.
module irrig_rr_picker
  import irrig_pkg::*;
#(
  parameter int unsigned MAX_OPEN = 2
) (
  input  logic [REQ_W-1:0] req,
  input  logic [1:0]       ptr,
  output logic [REQ_W-1:0] sel,
  output logic [1:0]       last_idx
);

  logic [1:0]  idx;
  int unsigned cnt;

  always_comb begin
    sel      = '0;
    last_idx = ptr;
    idx      = '0;
    cnt      = 0;
    for (int k = 0; k < REQ_W; k++) begin
`ifdef IRRIG_ZONE1_PRIORITY_EN
      // k[1] selects the zone, k[0] flips the starting valve within it.
      idx = {k[1], k[0] ^ ptr[0]};
`else
      idx = ptr + 2'(k);
`endif
      if (req[idx] && (cnt < MAX_OPEN)) begin
        sel[idx] = 1'b1;
        last_idx = idx;
        cnt      = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/irrig_valve_scheduler.sv
// Time-sliced round-robin valve scheduler sharing one pump between two zones.
// Optional IRRIG_ZONE1_PRIORITY_EN: zone 1 requests are served ahead of zone 2.
module irrig_valve_scheduler
  import irrig_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 16,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned MAX_OPEN     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] G1,
  input  logic [1:0] G2,
  input  logic       level_ok,
  output logic [1:0] R1,
  output logic [1:0] R2,
  output logic       busy,
  output logic       fault
);

  localparam int unsigned TW = $clog2(max_u(SLOT_CYCLES, GUARD_CYCLES) + 1);
  localparam logic [TW-1:0] SLOT_RELOAD  = TW'(SLOT_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_RELOAD = TW'(GUARD_CYCLES - 1);

  sched_state_t     state_q, state_d;
  logic [REQ_W-1:0] grant_q, grant_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       next_ptr_q, next_ptr_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic [REQ_W-1:0] req;
  logic [REQ_W-1:0] sel;
  logic [1:0]       last_idx;

  assign req = {G2, G1};

  irrig_rr_picker #(
    .MAX_OPEN(MAX_OPEN)
  ) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .sel     (sel),
    .last_idx(last_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    next_ptr_d = next_ptr_q;
    timer_d    = timer_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (!level_ok) begin
          state_d = FAULT;
          timer_d = GUARD_RELOAD;
        end else if (req != '0) begin
          state_d = GRANT;
          grant_d = sel;
          timer_d = SLOT_RELOAD;
`ifdef IRRIG_ZONE1_PRIORITY_EN
          next_ptr_d = {1'b0, ~ptr_q[0]};
`else
          next_ptr_d = last_idx + 2'd1;
`endif
        end
      end
      GRANT: begin
        // Every exit path closes all valves and advances the rotation.
        if (!level_ok || ((grant_q & req) == '0) || (timer_q == '0)) begin
          state_d = level_ok ? GUARD : FAULT;
          grant_d = '0;
          timer_d = GUARD_RELOAD;
          ptr_d   = next_ptr_q;
        end else begin
          grant_d = grant_q & req;
          timer_d = timer_q - TW'(1);
        end
      end
      GUARD: begin
        grant_d = '0;
        if (!level_ok) begin
          state_d = FAULT;
          timer_d = GUARD_RELOAD;
        end else if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        // FAULT: need GUARD_CYCLES consecutive good level samples to recover.
        grant_d = '0;
        if (!level_ok) begin
          timer_d = GUARD_RELOAD;
        end else if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      next_ptr_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      next_ptr_q <= next_ptr_d;
      timer_q    <= timer_d;
    end
  end

  assign R1    = grant_q[V_Z1B:V_Z1A];
  assign R2    = grant_q[V_Z2B:V_Z2A];
  assign busy  = (state_q == GRANT);
  assign fault = (state_q == FAULT);

endmodule
